// File: rtl/counter8_seq_if.sv
// Command channel between the test/config logic and the counter sequencer:
// valid/ready command transfer plus the completion/error report.
interface counter8_seq_if;
    logic       CMD_VALID;
    logic       CMD_READY;
    logic       CMD_DIR;
    logic [7:0] CMD_START;
    logic [7:0] CMD_STEPS;
    logic       DONE;
    logic       ERR;

    modport master (
        output CMD_VALID,
        output CMD_DIR,
        output CMD_START,
        output CMD_STEPS,
        input  CMD_READY,
        input  DONE,
        input  ERR
    );

    modport slave (
        input  CMD_VALID,
        input  CMD_DIR,
        input  CMD_START,
        input  CMD_STEPS,
        output CMD_READY,
        output DONE,
        output ERR
    );
endinterface

// File: rtl/counter8_seq.sv
// Sequencer that loads, starts, runs and checks one 8-bit start/end-controlled
// up/down counter for a single (direction, start, steps) command at a time.
module counter8_seq #(
    parameter bit CHK_EN = 1'b1
) (
    input  logic             CLK,
    input  logic             RESETn,
    counter8_seq_if.slave    cmd,
    input  logic             PAUSE,
    input  logic             ABORT,
    input  logic [7:0]       CNT_DOUT,
    output logic             MODE_SEL,
    output logic             LOAD,
    output logic [7:0]       DIN,
    output logic             INC_START,
    output logic             INC_END,
    output logic             DEC_START,
    output logic             DEC_END,
    output logic             HOLD,
    output logic             CLR
);

    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_RUN,
        S_CHECK,
        S_ABORT
    } state_t;

    state_t              state_q;
    state_t              state_d;

    logic [DATA_W-1:0]   rem_q;
    logic [DATA_W-1:0]   exp_q;
    logic                mode_q;
    logic [DATA_W-1:0]   din_q;
    logic                load_q;
    logic                inc_start_q;
    logic                dec_start_q;
    logic                clr_q;
    logic                ready_q;
    logic                done_q;
    logic                err_q;

    logic                accept;
    logic                end_pulse;
    logic                err_chk;
    logic                finishing;

    // Final counter value after 'steps' counts from 'start'; wraps modulo 256.
    function automatic logic [DATA_W-1:0] wrap_target(
        input logic              dir,
        input logic [DATA_W-1:0] start,
        input logic [DATA_W-1:0] steps
    );
        logic [DATA_W-1:0] t;
        if (dir) t = start + steps;
        else     t = start - steps;
        return t;
    endfunction

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        end_pulse = 1'b0;
        err_chk   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (cmd.CMD_VALID) begin
                    accept  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = (rem_q != '0) ? S_START : S_CHECK;
            end
            S_START: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (!PAUSE && rem_q == DATA_W'(1)) begin
                    end_pulse = 1'b1;
                    state_d   = S_CHECK;
                end
            end
            S_CHECK: begin
                err_chk = CHK_EN && (CNT_DOUT != exp_q);
                state_d = S_IDLE;
            end
            S_ABORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // Abort overrides every transition of an active command.
        if (ABORT && state_q != S_IDLE && state_q != S_ABORT)
            state_d = S_ABORT;
    end

    assign finishing = (state_q == S_CHECK || state_q == S_ABORT) && (state_d == S_IDLE);

    // Command capture and step bookkeeping
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            mode_q <= 1'b0;
            din_q  <= '0;
            rem_q  <= '0;
            exp_q  <= '0;
        end else begin
            if (accept) begin
                mode_q <= cmd.CMD_DIR;
                din_q  <= cmd.CMD_START;
                rem_q  <= cmd.CMD_STEPS;
                exp_q  <= wrap_target(cmd.CMD_DIR, cmd.CMD_START, cmd.CMD_STEPS);
            end else if (state_q == S_RUN && !PAUSE && rem_q != '0) begin
                rem_q <= rem_q - DATA_W'(1);
            end
        end
    end

    // Registered strobes follow the state being entered, so they are high
    // exactly for the cycle spent in that state.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            load_q      <= 1'b0;
            inc_start_q <= 1'b0;
            dec_start_q <= 1'b0;
            clr_q       <= 1'b0;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            load_q      <= (state_d == S_LOAD);
            inc_start_q <= (state_d == S_START) &&  mode_q;
            dec_start_q <= (state_d == S_START) && !mode_q;
            clr_q       <= (state_d == S_ABORT);
            ready_q     <= (state_d == S_IDLE);
            done_q      <= finishing;
            err_q       <= finishing && ((state_q == S_ABORT) || err_chk);
        end
    end

    // End pulses and hold must act in the current cycle, hence combinational.
    assign INC_END   = end_pulse &&  mode_q;
    assign DEC_END   = end_pulse && !mode_q;
    assign HOLD      = (state_q == S_RUN) && PAUSE;

    assign MODE_SEL  = mode_q;
    assign LOAD      = load_q;
    assign DIN       = din_q;
    assign INC_START = inc_start_q;
    assign DEC_START = dec_start_q;
    assign CLR       = clr_q;

    assign cmd.CMD_READY = ready_q;
    assign cmd.DONE      = done_q;
    assign cmd.ERR       = err_q;

endmodule

// File: tb/tb_counter8_seq.sv
// Bench for counter8_seq: behavioural counter in the loop, scoreboard of
// expected completions, two sequencers (checking on / off) sharing stimulus.
module tb_counter8_seq;

    logic CLK = 1'b0;
    logic RESETn = 1'b0;
    always #5 CLK = ~CLK;

    counter8_seq_if cif();
    counter8_seq_if cif0();

    logic       PAUSE, ABORT;
    logic [7:0] cnt, cnt_dout, off;
    logic       en;

    logic       mode_sel, load, inc_start, inc_end, dec_start, dec_end, hold, clr;
    logic [7:0] din;
    logic       mode_sel0, load0, inc_start0, inc_end0, dec_start0, dec_end0, hold0, clr0;
    logic [7:0] din0;

    assign cif0.CMD_VALID = cif.CMD_VALID;
    assign cif0.CMD_DIR   = cif.CMD_DIR;
    assign cif0.CMD_START = cif.CMD_START;
    assign cif0.CMD_STEPS = cif.CMD_STEPS;

    counter8_seq #(.CHK_EN(1'b1)) dut (
        .CLK(CLK), .RESETn(RESETn), .cmd(cif), .PAUSE(PAUSE), .ABORT(ABORT),
        .CNT_DOUT(cnt_dout), .MODE_SEL(mode_sel), .LOAD(load), .DIN(din),
        .INC_START(inc_start), .INC_END(inc_end), .DEC_START(dec_start),
        .DEC_END(dec_end), .HOLD(hold), .CLR(clr)
    );

    counter8_seq #(.CHK_EN(1'b0)) dut0 (
        .CLK(CLK), .RESETn(RESETn), .cmd(cif0), .PAUSE(PAUSE), .ABORT(ABORT),
        .CNT_DOUT(cnt_dout), .MODE_SEL(mode_sel0), .LOAD(load0), .DIN(din0),
        .INC_START(inc_start0), .INC_END(inc_end0), .DEC_START(dec_start0),
        .DEC_END(dec_end0), .HOLD(hold0), .CLR(clr0)
    );

    // Counter under control: clear > load > count; enable set by start, cleared by end.
    always @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            cnt <= 8'h00;
            en  <= 1'b0;
        end else if (clr) begin
            cnt <= 8'h00;
            en  <= 1'b0;
        end else if (load) begin
            cnt <= din;
        end else begin
            if (en && !hold) cnt <= mode_sel ? cnt + 8'h01 : cnt - 8'h01;
            if (inc_start || dec_start)  en <= 1'b1;
            else if (inc_end || dec_end) en <= 1'b0;
        end
    end
    assign cnt_dout = cnt + off;

    typedef struct {
        int         lat;
        bit         err1;
        bit         err0;
        logic [7:0] val;
        bit         dir;
        int         ist, ien, dst, den, hld, ld, cl;
    } exp_t;

    exp_t sb_q[$];
    int   acc_q[$];
    int   checks = 0;
    int   errors = 0;
    int   edges = 0;
    int   n_ist, n_ien, n_dst, n_den, n_hld, n_ld, n_cl, n_modebad;
    bit   cur_dir = 1'b0;
    bit   b2b = 1'b0;
    exp_t em;
    int   am;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input int lat, input bit e1, input bit e0, input logic [7:0] v,
                                input bit dir, input int ist, input int ien, input int dst,
                                input int den, input int hld, input int ld, input int cl);
        exp_t e;
        e.lat = lat; e.err1 = e1; e.err0 = e0; e.val = v; e.dir = dir;
        e.ist = ist; e.ien = ien; e.dst = dst; e.den = den;
        e.hld = hld; e.ld = ld; e.cl = cl;
        return e;
    endfunction

    always @(posedge CLK) edges <= edges + 1;

    // Monitor: per-cycle exclusivity, pulse tallies, scoreboard pop on DONE.
    always @(negedge CLK) begin
        if (RESETn) begin
            chk("exclusive", 32'($countones({load, inc_start | dec_start, inc_end | dec_end, clr}) <= 1), 32'd1);
            chk("inc_dec_overlap", 32'((inc_start | inc_end) & (dec_start | dec_end)), 32'd0);
            chk("err_without_done", 32'(cif.ERR & ~cif.DONE), 32'd0);
            n_ist += int'(inc_start); n_ien += int'(inc_end);
            n_dst += int'(dec_start); n_den += int'(dec_end);
            n_hld += int'(hold);      n_ld  += int'(load);
            n_cl  += int'(clr);
            if (mode_sel !== cur_dir) n_modebad++;
            if (cif.DONE) begin
                if (sb_q.size() == 0 || acc_q.size() == 0) begin
                    chk("unexpected_done", 32'(cif.DONE), 32'd0);
                end else begin
                    em = sb_q.pop_front();
                    am = acc_q.pop_front();
                    chk("latency", edges - am, em.lat);
                    chk("err", 32'(cif.ERR), 32'(em.err1));
                    chk("done_nochk", 32'(cif0.DONE), 32'd1);
                    chk("err_nochk", 32'(cif0.ERR), 32'(em.err0));
                    chk("final_value", 32'(cnt), 32'(em.val));
                    chk("inc_start_n", n_ist, em.ist);
                    chk("inc_end_n", n_ien, em.ien);
                    chk("dec_start_n", n_dst, em.dst);
                    chk("dec_end_n", n_den, em.den);
                    chk("hold_n", n_hld, em.hld);
                    chk("load_n", n_ld, em.ld);
                    chk("clr_n", n_cl, em.cl);
                    chk("mode_sel_held", n_modebad, 0);
                    chk("ready_in_done", 32'(cif.CMD_READY), 32'd1);
                end
            end
            if (cif.CMD_READY && cif.CMD_VALID) begin
                acc_q.push_back(edges + 1);
                if (cif.DONE) b2b = 1'b1;
                cur_dir = cif.CMD_DIR;
                n_ist = 0; n_ien = 0; n_dst = 0; n_den = 0;
                n_hld = 0; n_ld = 0;  n_cl = 0;  n_modebad = 0;
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic send(input bit dir, input logic [7:0] start, input logic [7:0] steps,
                        input exp_t e, input bit keep);
        int t = 0;
        cif.CMD_DIR   = dir;
        cif.CMD_START = start;
        cif.CMD_STEPS = steps;
        cif.CMD_VALID = 1'b1;
        sb_q.push_back(e);
        while (!cif.CMD_READY && t < 100) begin
            step(1);
            t++;
        end
        if (t >= 100) chk("accept_timeout", 32'(t), 32'd0);
        step(1);
        if (!keep) cif.CMD_VALID = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb_q.size() != 0 && t < 300) begin
            step(1);
            t++;
        end
        chk("drain", sb_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        cif.CMD_VALID = 1'b0; cif.CMD_DIR = 1'b0;
        cif.CMD_START = 8'h00; cif.CMD_STEPS = 8'h00;
        PAUSE = 1'b0; ABORT = 1'b0; off = 8'h00;
        n_ist = 0; n_ien = 0; n_dst = 0; n_den = 0;
        n_hld = 0; n_ld = 0;  n_cl = 0;  n_modebad = 0;

        step(2);
        chk("reset_outputs", 32'({mode_sel, load, din, inc_start, inc_end, dec_start,
                                  dec_end, hold, clr, cif.DONE, cif.ERR}), 32'd0);
        chk("reset_ready", 32'(cif.CMD_READY), 32'd1);
        RESETn = 1'b1;
        step(2);

        send(1'b1, 8'h10, 8'd5, mk(8, 0, 0, 8'h15, 1, 1, 1, 0, 0, 0, 1, 0), 1'b0);
        drain();

        send(1'b0, 8'h02, 8'd4, mk(7, 0, 0, 8'hFE, 0, 0, 0, 1, 1, 0, 1, 0), 1'b0);
        drain();

        send(1'b1, 8'hFE, 8'd4, mk(10, 0, 0, 8'h02, 1, 1, 1, 0, 0, 3, 1, 0), 1'b0);
        step(3);
        PAUSE = 1'b1;
        step(3);
        PAUSE = 1'b0;
        drain();

        send(1'b1, 8'hA5, 8'd0, mk(2, 0, 0, 8'hA5, 1, 0, 0, 0, 0, 0, 1, 0), 1'b0);
        drain();

        send(1'b1, 8'h30, 8'd6, mk(5, 1, 1, 8'h00, 1, 1, 0, 0, 0, 0, 1, 1), 1'b0);
        step(3);
        ABORT = 1'b1;
        step(1);
        ABORT = 1'b0;
        drain();

        off = 8'h01;
        send(1'b1, 8'h10, 8'd3, mk(6, 1, 0, 8'h13, 1, 1, 1, 0, 0, 0, 1, 0), 1'b0);
        drain();
        off = 8'h00;

        // Back-to-back: valid held high, second command taken in the DONE cycle.
        b2b = 1'b0;
        send(1'b1, 8'h40, 8'd2, mk(5, 0, 0, 8'h42, 1, 1, 1, 0, 0, 0, 1, 0), 1'b1);
        cif.CMD_DIR = 1'b0; cif.CMD_START = 8'h40; cif.CMD_STEPS = 8'd1;
        sb_q.push_back(mk(4, 0, 0, 8'h3F, 0, 0, 0, 1, 1, 0, 1, 0));
        for (int t = 0; t < 50 && !b2b; t++) step(1);
        cif.CMD_VALID = 1'b0;
        drain();
        chk("b2b_accept_in_done", 32'(b2b), 32'd1);

        // Reset in the middle of RUN: no DONE afterwards.
        send(1'b1, 8'h00, 8'd20, mk(23, 0, 0, 8'h14, 1, 1, 1, 0, 0, 0, 1, 0), 1'b0);
        step(5);
        #2;
        RESETn = 1'b0;
        sb_q.delete();
        acc_q.delete();
        #1;
        chk("midreset_outputs", 32'({mode_sel, load, din, inc_start, inc_end, dec_start,
                                     dec_end, hold, clr, cif.DONE, cif.ERR}), 32'd0);
        chk("midreset_ready", 32'(cif.CMD_READY), 32'd1);
        step(2);
        RESETn = 1'b1;
        step(30);
        chk("ready_after_reset", 32'(cif.CMD_READY), 32'd1);
        chk("no_pending_after_reset", acc_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
